seq_muldiv_unit: RTL and testbench

//   Iterative multiply/divide unit for the CPU datapath, replacing the single-cycle MUL ALU path.

---
 rtl/seq_muldiv_unit.sv | 214 +++++++++++++++++++++
 tb/tb_seq_muldiv_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_muldiv_unit.sv
// Iterative multiply/divide unit: one bit per clock.
// MUL uses radix-2 Booth, MULU uses shift-add, DIV/DIVU use restoring division
// on magnitudes with a single sign-fixup cycle. HI/LO hold the last result.
module seq_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULU = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;

    // Two's-complement negate when requested (used for |x| and sign fixup).
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        logic [WIDTH-1:0] r;
        if (neg) begin
            r = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t           state_q;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    // acc_q: Booth/shift-add accumulator, or partial remainder.
    // mpl_q: multiplier shifting out, or dividend shifting out / quotient shifting in.
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mpl_q;
    logic             q1_q;
    // m_q: multiplicand, or divisor magnitude.
    logic [WIDTH-1:0] m_q;
    logic             a_neg_q;
    logic             q_neg_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH:0]   booth_sum_s;
    logic [WIDTH:0]   usum_s;
    logic [WIDTH:0]   rsh_s;
    logic             rem_ge_s;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] mpl_d;
    logic             q1_d;
    logic [WIDTH-1:0] fix_hi_d;
    logic [WIDTH-1:0] fix_lo_d;
    logic             div_by_zero_s;

    // Unsigned add for MULU: the carry-out becomes the shift-in bit.
    assign usum_s   = {1'b0, acc_q} + (mpl_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    // Restoring division: remainder shifted left with the next dividend bit.
    assign rsh_s    = {acc_q, mpl_q[WIDTH-1]};
    assign rem_ge_s = (rsh_s >= {1'b0, m_q});

    assign div_by_zero_s = op[1] && (B == {WIDTH{1'b0}});

    // Booth add/subtract, one bit wider so A = most-negative value cannot overflow.
    always_comb begin
        booth_sum_s = {acc_q[WIDTH-1], acc_q};
        case ({mpl_q[0], q1_q})
            2'b01:   booth_sum_s = {acc_q[WIDTH-1], acc_q} + {m_q[WIDTH-1], m_q};
            2'b10:   booth_sum_s = {acc_q[WIDTH-1], acc_q} - {m_q[WIDTH-1], m_q};
            default: booth_sum_s = {acc_q[WIDTH-1], acc_q};
        endcase
    end

    // Next iteration values of the working registers for the current op.
    always_comb begin
        acc_d = acc_q;
        mpl_d = mpl_q;
        q1_d  = q1_q;
        case (op_q)
            OP_MUL: begin
                acc_d = booth_sum_s[WIDTH:1];
                mpl_d = {booth_sum_s[0], mpl_q[WIDTH-1:1]};
                q1_d  = mpl_q[0];
            end
            OP_MULU: begin
                acc_d = usum_s[WIDTH:1];
                mpl_d = {usum_s[0], mpl_q[WIDTH-1:1]};
                q1_d  = q1_q;
            end
            default: begin
                if (rem_ge_s) begin
                    acc_d = rsh_s[WIDTH-1:0] - m_q;
                    mpl_d = {mpl_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rsh_s[WIDTH-1:0];
                    mpl_d = {mpl_q[WIDTH-2:0], 1'b0};
                end
                q1_d = q1_q;
            end
        endcase
    end

    // Final result: signed DIV restores signs (quotient toward zero, remainder follows dividend).
    always_comb begin
        if (op_q == OP_DIV) begin
            fix_hi_d = cond_neg(acc_q, a_neg_q);
            fix_lo_d = cond_neg(mpl_q, q_neg_q);
        end else begin
            fix_hi_d = acc_q;
            fix_lo_d = mpl_q;
        end
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            cnt_q   <= {CNT_W{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            mpl_q   <= {WIDTH{1'b0}};
            q1_q    <= 1'b0;
            m_q     <= {WIDTH{1'b0}};
            a_neg_q <= 1'b0;
            q_neg_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        dbz_q <= 1'b0;
                        if (div_by_zero_s) begin
                            hi_q    <= A;
                            lo_q    <= {WIDTH{1'b1}};
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q   <= CNT_W'(WIDTH);
                            acc_q   <= {WIDTH{1'b0}};
                            q1_q    <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= S_ITER;
                            if (op[1]) begin
                                // Divide on magnitudes; signs only matter for signed DIV.
                                mpl_q   <= cond_neg(A, !op[0] && A[WIDTH-1]);
                                m_q     <= cond_neg(B, !op[0] && B[WIDTH-1]);
                                a_neg_q <= !op[0] && A[WIDTH-1];
                                q_neg_q <= !op[0] && (A[WIDTH-1] ^ B[WIDTH-1]);
                            end else begin
                                mpl_q   <= B;
                                m_q     <= A;
                                a_neg_q <= 1'b0;
                                q_neg_q <= 1'b0;
                            end
                        end
                    end
                end
                S_ITER: begin
                    acc_q <= acc_d;
                    mpl_q <= mpl_d;
                    q1_q  <= q1_d;
                    cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi_q    <= fix_hi_d;
                    lo_q    <= fix_lo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign HI          = hi_q;
    assign LO          = lo_q;

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Directed bench for seq_muldiv_unit with a cycle-level reference model
// computed from plain 64-bit arithmetic and the documented latencies.
module tb_seq_muldiv_unit;

    localparam int W = 32;

    logic          Clock = 1'b0;
    logic          Clear;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [W-1:0]  HI;
    logic [W-1:0]  LO;

    int n_checks = 0;
    int n_fail   = 0;

    seq_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .Clock       (Clock),
        .Clear       (Clear),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .HI          (HI),
        .LO          (LO)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Mathematical result {HI, LO} of an operation.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint sa, sb, q, m;
        logic [63:0] ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = 64'd0;
        case (o)
            2'b00: r = 64'(sa * sb);
            2'b01: r = ua * ub;
            2'b10: begin
                if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                else r = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
        return r;
    endfunction

    // Reference model: busy for W+1 cycles after accept, then a one-cycle done.
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic         m_dbz  = 1'b0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;
    logic [63:0]  m_pend = '0;

    always @(posedge Clock) begin
        if (!Clear) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                end
            end else if (!m_done && start) begin
                if (op[1] && B == 32'd0) begin
                    m_done <= 1'b1;
                    m_dbz  <= 1'b1;
                    m_hi   <= A;
                    m_lo   <= 32'hFFFFFFFF;
                end else begin
                    m_dbz  <= 1'b0;
                    m_left <= W + 1;
                    m_pend <= ref_result(op, A, B);
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge Clock) begin
        chk("cmp_busy", 64'(busy), 64'(m_left > 0));
        chk("cmp_done", 64'(done), 64'(m_done));
        chk("cmp_dbz",  64'(div_by_zero), 64'(m_dbz));
        chk("cmp_hi",   64'(HI), 64'(m_hi));
        chk("cmp_lo",   64'(LO), 64'(m_lo));
    end

    // Issue one operation, wait for done, pin result/latency to literals.
    task automatic run_op(input string nm, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input logic exp_dbz,
                          input int exp_lat, input int exp_busy, input bit poke);
        int lat;
        int busy_n;
        bit seen;
        lat    = 0;
        busy_n = 0;
        seen   = 1'b0;
        @(negedge Clock);
        start = 1'b1; op = o; A = a; B = b;
        for (int n = 1; n <= W + 8; n++) begin
            @(negedge Clock);
            if (poke && n >= 4 && n < 7) begin
                start = 1'b1; op = 2'b01; A = 32'd3; B = 32'd3;
            end else begin
                start = 1'b0; op = 2'($urandom); A = $urandom; B = $urandom;
            end
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
                lat  = n;
                break;
            end
        end
        start = 1'b0;
        if (!seen) $display("FAIL %s_timeout: got no done expected done", nm);
        chk({nm, "_lat"},  64'(lat), 64'(exp_lat));
        chk({nm, "_busy"}, 64'(busy_n), 64'(exp_busy));
        chk({nm, "_hi"},   64'(HI), 64'(exp_hi));
        chk({nm, "_lo"},   64'(LO), 64'(exp_lo));
        chk({nm, "_dbz"},  64'(div_by_zero), 64'(exp_dbz));
    endtask

    initial begin
        Clear = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
        repeat (2) @(negedge Clock);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {HI, LO}, 64'd0);
        chk("rst_dbz",  64'(div_by_zero), 64'd0);
        Clear = 1'b1;

        run_op("mulu_small", 2'b01, 32'h12, 32'h14, 32'h0, 32'h168, 1'b0, 34, 33, 1'b0);
        run_op("mul_neg",    2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34, 33, 1'b0);
        run_op("mulu_max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0, 34, 33, 1'b0);
        run_op("mul_minmin", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 34, 33, 1'b0);
        run_op("mul_min1",   2'b00, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000, 1'b0, 34, 33, 1'b0);
        run_op("divu",       2'b11, 32'h18, 32'd5, 32'd4, 32'd4, 1'b0, 34, 33, 1'b0);
        run_op("div_neg",    2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 33, 1'b0);
        run_op("div_negb",   2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 34, 33, 1'b0);
        run_op("div_wrap",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34, 33, 1'b0);
        run_op("divu_small", 2'b11, 32'd5, 32'd7, 32'd5, 32'd0, 1'b0, 34, 33, 1'b0);
        run_op("divu_max",   2'b11, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0, 34, 33, 1'b0);
        run_op("div_zero",   2'b10, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1, 1, 0, 1'b0);
        run_op("divu_zero",  2'b11, 32'h0, 32'd0, 32'h0, 32'hFFFFFFFF, 1'b1, 1, 0, 1'b0);
        run_op("dbz_clear",  2'b11, 32'd100, 32'd10, 32'd0, 32'd10, 1'b0, 34, 33, 1'b0);
        run_op("poke",       2'b01, 32'd1000, 32'd1000, 32'd0, 32'd1000000, 1'b0, 34, 33, 1'b1);
        @(negedge Clock);
        chk("poke_single_done", 64'(done), 64'd0);

        // Reset in the middle of an iteration discards the operation.
        @(negedge Clock);
        start = 1'b1; op = 2'b01; A = 32'd9; B = 32'd9;
        @(negedge Clock);
        start = 1'b0;
        repeat (9) @(negedge Clock);
        Clear = 1'b0;
        @(negedge Clock);
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_done", 64'(done), 64'd0);
        chk("clr_hilo", {HI, LO}, 64'd0);
        Clear = 1'b1;
        run_op("after_clr", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 34, 33, 1'b0);

        repeat (3) @(negedge Clock);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
